// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and bus widths for the SRAM responder.
package axil_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

endpackage

// File: rtl/axil_lat_cnt.sv
// Loadable down-counter with a zero flag; paces the read and write response latency.
module axil_lat_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite SRAM responder: independent read and write FSMs over one word array,
// with programmable (optionally LFSR-jittered) response latency.
module axil_sram_slave
    import axil_pkg::*;
#(
    parameter int              DEPTH      = 4096,
    parameter logic [31:0]     BASE       = 32'h8000_0000,
    parameter int              RD_LAT     = 1,
    parameter int              WR_LAT     = 1,
    parameter int              RAND_DELAY = 0,
    parameter logic [7:0]      LFSR_SEED  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 4);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH) << 2;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE) && ((ADDR_W+1)'(a - BASE) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 2);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic strb_unused;
    assign strb_unused = ^wstrb[7:4];

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running
    logic [7:0] lfsr_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end

    logic [CNT_W-1:0] extra_lat;
    assign extra_lat = (RAND_DELAY != 0) ? CNT_W'(lfsr_reg[1:0]) : '0;

    // ---------------- read path ----------------
    r_state_t          r_state_reg;
    logic [ADDR_W-1:0] r_addr_reg;
    logic              arready_reg, rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [1:0]        rresp_reg;
    logic              ar_fire, r_zero, r_sample;
    logic [CNT_W-1:0]  r_lat;
    logic [ADDR_W-1:0] r_sample_addr;

    assign ar_fire       = arready_reg && arvalid;
    assign r_lat         = CNT_W'(RD_LAT - 1) + extra_lat;
    assign r_sample      = (ar_fire && (r_lat == '0)) || ((r_state_reg == R_WAIT) && r_zero);
    assign r_sample_addr = (r_state_reg == R_IDLE) ? araddr : r_addr_reg;

    // The wait state itself costs one cycle, so the counter is loaded one short.
    axil_lat_cnt #(.W(CNT_W)) u_rd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (ar_fire),
        .load_val (r_lat - CNT_W'(1)),
        .dec      (r_state_reg == R_WAIT),
        .zero     (r_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b1;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_fire) begin
                        arready_reg <= 1'b0;
                        r_state_reg <= (r_lat == '0) ? R_RESP : R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_zero) r_state_reg <= R_RESP;
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid_reg  <= 1'b0;
                        arready_reg <= 1'b1;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
            if (r_sample) begin
                rvalid_reg <= 1'b1;
                if (in_range(r_sample_addr)) begin
                    rdata_reg <= mem[word_idx(r_sample_addr)];
                    rresp_reg <= RESP_OKAY;
                end else begin
                    rdata_reg <= '0;
                    rresp_reg <= RESP_SLVERR;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ar_fire) r_addr_reg <= araddr;
    end

    // ---------------- write path ----------------
    w_state_t          w_state_reg;
    logic [ADDR_W-1:0] w_addr_reg;
    logic [DATA_W-1:0] w_data_reg;
    logic [3:0]        w_strb_reg;
    logic              awready_reg, wready_reg, bvalid_reg;
    logic [1:0]        bresp_reg;
    logic              aw_fire, w_fire, w_both, w_zero, w_commit, mem_we;
    logic [CNT_W-1:0]  w_lat;
    logic [ADDR_W-1:0] w_eff_addr;
    logic [DATA_W-1:0] w_eff_data;
    logic [3:0]        w_eff_strb;

    assign aw_fire = awready_reg && awvalid;
    assign w_fire  = wready_reg && wvalid;
    // A dropped ready means that half of the request is already held.
    assign w_both  = (w_state_reg == W_IDLE) && (aw_fire || !awready_reg) && (w_fire || !wready_reg);
    assign w_lat   = CNT_W'(WR_LAT - 1) + extra_lat;

    assign w_eff_addr = aw_fire ? awaddr : w_addr_reg;
    assign w_eff_data = w_fire ? wdata : w_data_reg;
    assign w_eff_strb = w_fire ? wstrb[3:0] : w_strb_reg;

    assign w_commit = (w_both && (w_lat == '0)) || ((w_state_reg == W_WAIT) && w_zero);
    assign mem_we   = w_commit && in_range(w_eff_addr);

    axil_lat_cnt #(.W(CNT_W)) u_wr_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_both),
        .load_val (w_lat - CNT_W'(1)),
        .dec      (w_state_reg == W_WAIT),
        .zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_fire) awready_reg <= 1'b0;
                    if (w_fire)  wready_reg  <= 1'b0;
                    if (w_both)  w_state_reg <= (w_lat == '0) ? W_RESP : W_WAIT;
                end
                W_WAIT: begin
                    if (w_zero) w_state_reg <= W_RESP;
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
            if (w_commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= in_range(w_eff_addr) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aw_fire) w_addr_reg <= awaddr;
        if (w_fire) begin
            w_data_reg <= wdata;
            w_strb_reg <= wstrb[3:0];
        end
    end

    // Same-edge read sampling sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (w_eff_strb[b]) mem[word_idx(w_eff_addr)][8*b +: 8] <= w_eff_data[8*b +: 8];
            end
        end
    end

    assign arready = arready_reg;
    assign rvalid  = rvalid_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;
    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;

endmodule

// File: tb/tb_axil_sram_slave.sv
// Bench for axil_sram_slave: a fast instance (latency 1) and a slow one (latency 3),
// both checked against a word-array reference model.
module tb_axil_sram_slave;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH0 = 4096;
    localparam int          DEPTH1 = 64;
    localparam int          LAT1   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [7:0]  wstrb = '0;
    logic arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;

    logic        arready0, rvalid0, awready0, wready0, bvalid0;
    logic [31:0] rdata0;
    logic [1:0]  rresp0, bresp0;
    logic        arready1, rvalid1, awready1, wready1, bvalid1;
    logic [31:0] rdata1;
    logic [1:0]  rresp1, bresp1;

    logic        arready_m, rvalid_m, awready_m, wready_m, bvalid_m;
    logic [31:0] rdata_m;
    logic [1:0]  rresp_m, bresp_m;

    assign arready_m = sel ? arready1 : arready0;
    assign rvalid_m  = sel ? rvalid1  : rvalid0;
    assign awready_m = sel ? awready1 : awready0;
    assign wready_m  = sel ? wready1  : wready0;
    assign bvalid_m  = sel ? bvalid1  : bvalid0;
    assign rdata_m   = sel ? rdata1   : rdata0;
    assign rresp_m   = sel ? rresp1   : rresp0;
    assign bresp_m   = sel ? bresp1   : bresp0;

    int tests = 0;
    int fails = 0;
    logic [31:0] model [int];

    always #5 clk = ~clk;

    axil_sram_slave #(.DEPTH(DEPTH0)) dut0 (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid & ~sel), .arready(arready0),
        .rdata(rdata0), .rresp(rresp0), .rvalid(rvalid0), .rready(rready & ~sel),
        .awaddr(awaddr), .awvalid(awvalid & ~sel), .awready(awready0),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & ~sel), .wready(wready0),
        .bresp(bresp0), .bvalid(bvalid0), .bready(bready & ~sel)
    );

    axil_sram_slave #(.DEPTH(DEPTH1), .RD_LAT(LAT1), .WR_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid & sel), .arready(arready1),
        .rdata(rdata1), .rresp(rresp1), .rvalid(rvalid1), .rready(rready & sel),
        .awaddr(awaddr), .awvalid(awvalid & sel), .awready(awready1),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & sel), .wready(wready1),
        .bresp(bresp1), .bvalid(bvalid1), .bready(bready & sel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input bit s, input logic [31:0] a);
        longint span;
        span = 4 * longint'(s ? DEPTH1 : DEPTH0);
        return (a >= BASE) && (longint'(a) < longint'(BASE) + span);
    endfunction

    function automatic int key(input bit s, input logic [31:0] a);
        return (s ? 32'h0010_0000 : 0) + int'((a - BASE) >> 2);
    endfunction

    // lead > 0: W goes first by lead cycles; lead < 0: AW goes first; 0: same cycle
    task automatic do_write(input bit s, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] st, input int lead, input string tag);
        int lat;
        int gap;
        logic [31:0] w;
        logic [1:0] exp_r;
        sel = s;
        gap = (lead < 0) ? -lead : lead;
        if (lead >= 0) begin wvalid = 1'b1; wdata = d; wstrb = {4'($urandom), st}; end
        if (lead <= 0) begin awvalid = 1'b1; awaddr = a; end
        if (lead != 0) begin
            tick();
            if (lead > 0) begin
                wvalid = 1'b0;
                check({tag, "_half_rdy"}, {62'd0, awready_m, wready_m}, 64'b10);
            end else begin
                awvalid = 1'b0;
                check({tag, "_half_rdy"}, {62'd0, awready_m, wready_m}, 64'b01);
            end
            repeat (gap - 1) tick();
            if (lead > 0) begin awvalid = 1'b1; awaddr = a; end
            else begin wvalid = 1'b1; wdata = d; wstrb = {4'($urandom), st}; end
        end
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        lat = 1;
        while (bvalid_m !== 1'b1 && lat < 40) begin tick(); lat++; end
        check({tag, "_blat"}, 64'(lat), 64'(s ? LAT1 : 1));
        if (in_rng(s, a)) begin
            exp_r = 2'b00;
            if (model.exists(key(s, a)) || st == 4'hF) begin
                w = model.exists(key(s, a)) ? model[key(s, a)] : 32'h0;
                for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = d[8*b +: 8];
                model[key(s, a)] = w;
            end
        end else begin
            exp_r = 2'b10;
        end
        check({tag, "_bresp"}, 64'(bresp_m), 64'(exp_r));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, "_after_b"}, {61'd0, bvalid_m, awready_m, wready_m}, 64'b011);
    endtask

    task automatic do_read(input bit s, input logic [31:0] a, input int stall,
                           input string tag, output logic [31:0] got);
        int lat;
        logic [31:0] exp_d;
        logic [1:0] exp_r;
        sel = s;
        arvalid = 1'b1;
        araddr  = a;
        tick();
        arvalid = 1'b0;
        check({tag, "_ar_low"}, 64'(arready_m), 64'd0);
        lat = 1;
        while (rvalid_m !== 1'b1 && lat < 40) begin tick(); lat++; end
        check({tag, "_rlat"}, 64'(lat), 64'(s ? LAT1 : 1));
        if (in_rng(s, a)) begin
            exp_d = model.exists(key(s, a)) ? model[key(s, a)] : 32'hx;
            exp_r = 2'b00;
        end else begin
            exp_d = 32'h0;
            exp_r = 2'b10;
        end
        check({tag, "_rdata"}, 64'(rdata_m), 64'(exp_d));
        check({tag, "_rresp"}, 64'(rresp_m), 64'(exp_r));
        got = rdata_m;
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall"}, {30'd0, arready_m, rvalid_m, rdata_m}, {30'd0, 1'b0, 1'b1, exp_d});
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, "_after_r"}, {62'd0, rvalid_m, arready_m}, 64'b01);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] addr;
        int r;

        // reset state of both instances
        rst = 1'b1;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            check("rst_flags", {59'd0, arready_m, awready_m, wready_m, rvalid_m, bvalid_m}, 64'b11100);
            check("rst_data", {28'd0, rresp_m, bresp_m, rdata_m}, 64'd0);
        end
        rst = 1'b0;
        tick();

        // same-cycle AW/W, then readback
        do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, "t1_wr");
        do_read(0, 32'h8000_0010, 0, "t1_rd", got);
        check("t1_const", 64'(got), 64'h0000_0000_DEAD_BEEF);

        // W three cycles ahead of AW, partial strobes
        do_write(0, 32'h8000_0010, 32'h1122_3344, 4'b0101, 3, "t2_wr");
        do_read(0, 32'h8000_0012, 0, "t2_rd", got);
        check("t2_const", 64'(got), 64'h0000_0000_DE22_BE44);

        // out of range on both paths; word 0 aliases the upper bound index
        do_write(0, BASE, 32'h0BAD_F00D, 4'hF, 0, "t3_pre");
        do_read(0, 32'h7FFF_FFFC, 0, "t3_rd_lo", got);
        do_write(0, BASE + 32'(4 * DEPTH0), 32'h1234_5678, 4'hF, -2, "t3_wr_hi");
        do_write(0, BASE, 32'hFFFF_FFFF, 4'h0, 1, "t3_wr_nostrb");
        do_read(0, BASE, 0, "t3_rd0", got);
        check("t3_unchanged", 64'(got), 64'h0000_0000_0BAD_F00D);

        // slow instance: latency 3 with a 5-cycle rready stall
        do_write(1, BASE + 32'd8, 32'hCAFE_F00D, 4'hF, 1, "t4_wr");
        do_read(1, BASE + 32'd8, 5, "t4_rd", got);

        // read sample and write commit to the same word on the same edge
        do_write(0, BASE + 32'h20, 32'h0000_000A, 4'hF, 0, "t5_pre");
        sel = 1'b0;
        araddr = BASE + 32'h20; arvalid = 1'b1;
        awaddr = BASE + 32'h20; awvalid = 1'b1;
        wdata = 32'h0000_000B; wstrb = 8'h0F; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check("t5_valids", {62'd0, rvalid_m, bvalid_m}, 64'b11);
        check("t5_old", 64'(rdata_m), 64'h0000_0000_0000_000A);
        model[key(0, BASE + 32'h20)] = 32'h0000_000B;
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        check("t5_idle", {59'd0, rvalid_m, bvalid_m, arready_m, awready_m, wready_m}, 64'b00111);
        do_read(0, BASE + 32'h20, 0, "t5_rd", got);
        check("t5_new", 64'(got), 64'h0000_0000_0000_000B);

        // reset while the slow instance sits in its write wait
        do_write(1, BASE + 32'd12, 32'h5555_AAAA, 4'hF, 0, "t6_pre");
        sel = 1'b1;
        awaddr = BASE + 32'd12; awvalid = 1'b1;
        wdata = 32'h1234_5678; wstrb = 8'hFF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t6_wait", {61'd0, bvalid_m, awready_m, wready_m}, 64'b000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst", {61'd0, bvalid_m, awready_m, wready_m}, 64'b011);
        repeat (4) tick();
        check("t6_no_b", 64'(bvalid_m), 64'd0);
        do_read(1, BASE + 32'd12, 0, "t6_rd", got);
        check("t6_kept", 64'(got), 64'h0000_0000_5555_AAAA);

        // randomized traffic on the fast instance
        for (int i = 0; i < 16; i++) begin
            do_write(0, BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF, 0, "pre");
        end
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0) addr = BASE + 32'(4 * DEPTH0) + 32'(4 * $urandom_range(0, 15));
            else        addr = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15));
            addr[1:0] = 2'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_write(0, addr, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3, "rnd_wr");
            else
                do_read(0, addr, int'($urandom_range(0, 2)), "rnd_rd", got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
